loop_controller: RTL and testbench
==================================

// Module: loop_controller
// PURPOSE
//  Zero-overhead hardware loop unit beside program_sequencer. Holds a LIFO of nested
//  loop frames {start, end, remaining}. Drives a jump request back to the sequencer
//  whenever pc reaches the end address of the innermost loop with iterations left.
//  Integrator ORs loop_jmp/loop_addr into the sequencer jump path below sync reset.
// PARAMETERS
//  ADDR_W  8  program memory address width (matches pc/pm_addr)
//  CNT_W   8  iteration count width
//  DEPTH   4  max nesting depth (number of loop frames)
// PORTS
//  clk           in   1          system clock, all state on rising edge
//  sync_reset_n  in   1          synchronous reset, active low
//  pc            in   ADDR_W     current program counter from sequencer
//  loop_start    in   1          decoded LOOP instruction executing at pc (1-cycle pulse)
//  loop_count    in   CNT_W      iteration count of LOOP instruction
//  loop_end_addr in   ADDR_W     address of last body instruction, inclusive
//  loop_break    in   1          decoded BREAK instruction (only with LOOP_BREAK_EN)
//  loop_jmp      out  1          request sequencer to load loop_addr as next pm_addr
//  loop_addr     out  ADDR_W     jump target = start address of innermost loop
//  loop_active   out  1          depth != 0
//  loop_depth    out  clog2(DEPTH+1)  number of frames on stack
//  loop_err      out  1          sticky: overflow, or start/end collision
// BEHAVIOUR
//  - Reset (sync_reset_n==0 at edge): depth=0, frames cleared, loop_err=0. While
//    sync_reset_n==0, loop_jmp=0, loop_addr=0 (comb gated).
//  - States from depth: IDLE (0), RUN (1..DEPTH-1), FULL (DEPTH).
//  - Push: loop_start=1 at edge, not FULL -> frame {start=pc+1 (wraps 0xFF->0x00
//    at ADDR_W=8), end=loop_end_addr, remaining=max(loop_count,1)}; depth+1.
//    Count 0 treated as 1 (body runs once, no jump).
//  - Push when FULL: frame ignored, depth unchanged, loop_err<=1.
//  - End match (comb): only top frame compared. loop_jmp=1 iff active && !loop_start
//    && pc==top.end && top.remaining>1; loop_addr=top.start. Zero latency: same
//    cycle as pc==end, so pm_addr redirects to start with no bubble.
//  - At edge with end match: remaining>1 -> remaining-1; remaining==1 -> pop
//    (depth-1), no jump, execution falls through to end+1.
//  - Outer loop sharing inner end address: only inner handled that cycle; outer
//    match missed (programming error, not flagged).
//  - loop_start and end match same cycle: push wins, top not decremented, no jump,
//    loop_err<=1.
//  - Sequencer branches out of a body do not pop; frame persists until end match,
//    reset, or break.
//  - loop_addr = top.start whenever active (even when loop_jmp=0); 0 when IDLE.
//  - loop_err cleared only by reset.
// CONFIGURATION
//  LOOP_BREAK_EN defined: loop_break port present; loop_break=1 at edge with depth>0
//    pops top frame, no jump; with depth==0 ignored. Break beats end match and
//    beats loop_start (start ignored, loop_err<=1).
//  LOOP_BREAK_EN undefined: no loop_break port; frames leave only by end match/reset.
// TESTING
//  1 Reset: hold sync_reset_n=0 2 cycles -> loop_jmp=0, depth=0, loop_err=0, addr=0.
//  2 Single: start at pc=0x10,count=3,end=0x14 -> loop_jmp=1,addr=0x11 at pc=0x14
//    passes 1,2; pass 3 loop_jmp=0, pc->0x15, depth 1->0.
//  3 Nested: outer pc=0x20 cnt=2 end=0x28, inner pc=0x22 cnt=2 end=0x25 -> inner
//    jumps to 0x23 once per outer pass; outer jumps to 0x21 once; total body 0x23-0x25 x4.
//  4 Overflow (DEPTH=4): 5 nested starts -> depth=4, loop_err=1, 5th end never jumps.
//  5 Count 0 and wrap: start at pc=0xFF,cnt=0,end=0x02 -> start=0x00, no jump, pop at 0x02.
//  6 Reset mid-loop: sync_reset_n=0 at pc=end with remaining=3 -> loop_jmp=0, depth=0
//    next cycle; with LOOP_BREAK_EN, break in 2-deep loop -> depth=1, outer still jumps.

Source files
------------

// File: rtl/loop_controller.sv
// Zero-overhead hardware loop unit: LIFO of nested {start, end, remaining} frames,
// redirecting the sequencer at the innermost end address. Optional LOOP_BREAK_EN adds loop_break.
module loop_controller #(
    parameter  int ADDR_W = 8,
    parameter  int CNT_W  = 8,
    parameter  int DEPTH  = 4,
    localparam int DW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              sync_reset_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              loop_start,
    input  logic [CNT_W-1:0]  loop_count,
    input  logic [ADDR_W-1:0] loop_end_addr,
`ifdef LOOP_BREAK_EN
    input  logic              loop_break,
`endif
    output logic              loop_jmp,
    output logic [ADDR_W-1:0] loop_addr,
    output logic              loop_active,
    output logic [DW-1:0]     loop_depth,
    output logic              loop_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

    state_t                         state_q, state_d;
    logic [DW-1:0]                  depth_q, depth_d;
    logic                           err_q, err_d;
    logic [DEPTH-1:0][ADDR_W-1:0]   start_q, start_d;
    logic [DEPTH-1:0][ADDR_W-1:0]   end_q, end_d;
    logic [DEPTH-1:0][CNT_W-1:0]    rem_q, rem_d;

    logic              active, full, end_hit, brk;
    logic [IDX_W-1:0]  top_idx, push_idx;
    logic [ADDR_W-1:0] top_start, top_end;
    logic [CNT_W-1:0]  top_rem, push_cnt;

    assign active    = (state_q != S_IDLE);
    assign full      = (state_q == S_FULL);
    assign top_idx   = IDX_W'(depth_q - 1'b1);
    assign push_idx  = IDX_W'(depth_q);
    assign top_start = start_q[top_idx];
    assign top_end   = end_q[top_idx];
    assign top_rem   = rem_q[top_idx];
    assign end_hit   = active && (pc == top_end);
    // A zero count still runs the body once, so it is stored as one pass.
    assign push_cnt  = (loop_count == '0) ? CNT_W'(1) : loop_count;

`ifdef LOOP_BREAK_EN
    assign brk = loop_break && active;
`else
    assign brk = 1'b0;
`endif

    assign loop_jmp    = sync_reset_n && end_hit && !loop_start && !brk && (top_rem > CNT_W'(1));
    assign loop_addr   = (sync_reset_n && active) ? top_start : '0;
    assign loop_active = active;
    assign loop_depth  = depth_q;
    assign loop_err    = err_q;

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        rem_d   = rem_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (brk) begin
            depth_d = depth_q - 1'b1;
            if (loop_start) err_d = 1'b1;
        end else if (loop_start) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                start_d[push_idx] = ADDR_W'(pc + 1'b1);
                end_d[push_idx]   = loop_end_addr;
                rem_d[push_idx]   = push_cnt;
                depth_d           = depth_q + 1'b1;
            end
            // The end match on the old top is lost this cycle: flag it.
            if (end_hit) err_d = 1'b1;
        end else if (end_hit) begin
            if (top_rem > CNT_W'(1)) rem_d[top_idx] = top_rem - 1'b1;
            else                     depth_d = depth_q - 1'b1;
        end

        if (depth_d == '0)            state_d = S_IDLE;
        else if (depth_d == DW'(DEPTH)) state_d = S_FULL;
        else                          state_d = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            start_q <= start_d;
            end_q   <= end_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_loop_controller.sv
// Self-checking bench for loop_controller: directed spec scenarios plus randomized
// stimulus checked against a queue-based frame-stack model.
module tb_loop_controller;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, ls, brk;
    logic [7:0] pc, cnt, ea;
    logic       loop_jmp, loop_active, loop_err;
    logic [7:0] loop_addr;
    logic [2:0] loop_depth;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    loop_controller #(.ADDR_W(8), .CNT_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .sync_reset_n(rst_n), .pc(pc), .loop_start(ls),
        .loop_count(cnt), .loop_end_addr(ea),
`ifdef LOOP_BREAK_EN
        .loop_break(brk),
`endif
        .loop_jmp(loop_jmp), .loop_addr(loop_addr), .loop_active(loop_active),
        .loop_depth(loop_depth), .loop_err(loop_err)
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        int         rem;
    } frame_t;

    frame_t fr[$];
    bit     m_err;

    // Reference: the loop stack as a queue, advanced once per clock edge.
    function automatic void model_step(bit r, logic [7:0] p, bit l, logic [7:0] c, logic [7:0] e, bit b);
        frame_t t;
        bit hit;
        if (!r) begin
            fr.delete();
            m_err = 0;
            return;
        end
        hit = (fr.size() > 0) && (p == fr[fr.size()-1].e);
        if (b && fr.size() > 0) begin
            void'(fr.pop_back());
            if (l) m_err = 1;
        end else if (l) begin
            if (fr.size() == DEPTH) m_err = 1;
            else begin
                t.s = p + 8'd1; t.e = e; t.rem = (c == 0) ? 1 : int'(c);
                fr.push_back(t);
            end
            if (hit) m_err = 1;
        end else if (hit) begin
            t = fr[fr.size()-1];
            if (t.rem > 1) begin
                t.rem--;
                fr[fr.size()-1] = t;
            end else void'(fr.pop_back());
        end
    endfunction

    function automatic bit e_jmp();
        if (!rst_n || fr.size() == 0 || ls || brk) return 0;
        return (pc == fr[fr.size()-1].e) && (fr[fr.size()-1].rem > 1);
    endfunction

    function automatic logic [7:0] e_addr();
        if (!rst_n || fr.size() == 0) return 8'h00;
        return fr[fr.size()-1].s;
    endfunction

    task automatic set(input bit r, input logic [7:0] p, input bit l, input logic [7:0] c, input logic [7:0] e);
        rst_n = r; pc = p; ls = l; cnt = c; ea = e; brk = 1'b0;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, pc, ls, cnt, ea, brk);
        #1;
    endtask

    task automatic do_reset();
        set(0, 8'h00, 0, 8'h00, 8'h00);
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (loop_jmp !== 1'b0) begin n_fail++; $display("FAIL reset_jmp got %0h want 0", loop_jmp); end
        n_chk++; if (loop_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %0h want 0", loop_addr); end
        n_chk++; if (loop_depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth got %0d want 0", loop_depth); end
        n_chk++; if (loop_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h want 0", loop_err); end
        n_chk++; if (loop_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %0h want 0", loop_active); end
    endtask

    task automatic test_single();
        do_reset();
        set(1, 8'h10, 1, 8'd3, 8'h14);
        tick();
        n_chk++; if (loop_depth !== 3'd1) begin n_fail++; $display("FAIL single_push_depth got %0d want 1", loop_depth); end
        for (int pass = 1; pass <= 3; pass++) begin
            for (int p = 8'h11; p <= 8'h14; p++) begin
                set(1, 8'(p), 0, 8'd0, 8'h00);
                if (p == 8'h14) begin
                    n_chk++;
                    if (loop_jmp !== (pass < 3)) begin n_fail++; $display("FAIL single_jmp pass %0d got %0h want %0h", pass, loop_jmp, pass < 3); end
                    n_chk++;
                    if (loop_addr !== 8'h11) begin n_fail++; $display("FAIL single_addr pass %0d got %0h want 11", pass, loop_addr); end
                end
                tick();
            end
        end
        set(1, 8'h15, 0, 8'd0, 8'h00);
        n_chk++; if (loop_depth !== 3'd0) begin n_fail++; $display("FAIL single_pop_depth got %0d want 0", loop_depth); end
        n_chk++; if (loop_jmp !== 1'b0 || loop_active !== 1'b0) begin n_fail++; $display("FAIL single_after got jmp=%0h act=%0h want 0 0", loop_jmp, loop_active); end
    endtask

    // Emulates the sequencer: pc follows loop_jmp/loop_addr, else increments.
    task automatic test_nested();
        logic [7:0] p, np;
        int j21 = 0, j23 = 0, v24 = 0;
        do_reset();
        p = 8'h20;
        for (int i = 0; i < 100 && p != 8'h29; i++) begin
            set(1, p, (p == 8'h20) || (p == 8'h22), 8'd2, (p == 8'h20) ? 8'h28 : 8'h25);
            if (loop_jmp) begin
                if (loop_addr == 8'h23) j23++;
                else if (loop_addr == 8'h21) j21++;
            end
            if (p == 8'h24) v24++;
            np = loop_jmp ? loop_addr : p + 8'd1;
            tick();
            p = np;
        end
        n_chk++; if (p !== 8'h29) begin n_fail++; $display("FAIL nested_exit got pc %0h want 29", p); end
        n_chk++; if (j23 != 2) begin n_fail++; $display("FAIL nested_inner_jumps got %0d want 2", j23); end
        n_chk++; if (j21 != 1) begin n_fail++; $display("FAIL nested_outer_jumps got %0d want 1", j21); end
        n_chk++; if (v24 != 4) begin n_fail++; $display("FAIL nested_body_passes got %0d want 4", v24); end
        n_chk++; if (loop_depth !== 3'd0) begin n_fail++; $display("FAIL nested_depth got %0d want 0", loop_depth); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set(1, 8'(8'h30 + k), 1, 8'd2, 8'(8'h3F - k));
            tick();
        end
        n_chk++; if (loop_depth !== 3'd4) begin n_fail++; $display("FAIL ovf_depth got %0d want 4", loop_depth); end
        n_chk++; if (loop_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %0h want 1", loop_err); end
        set(1, 8'h3B, 0, 8'd0, 8'h00);
        n_chk++; if (loop_jmp !== 1'b0) begin n_fail++; $display("FAIL ovf_5th_end got %0h want 0", loop_jmp); end
        tick();
        set(1, 8'h3C, 0, 8'd0, 8'h00);
        n_chk++; if (loop_jmp !== 1'b1 || loop_addr !== 8'h34) begin n_fail++; $display("FAIL ovf_4th_end got %0h/%0h want 1/34", loop_jmp, loop_addr); end
        tick();
    endtask

    task automatic test_wrap_zero();
        do_reset();
        set(1, 8'hFF, 1, 8'd0, 8'h02);
        tick();
        set(1, 8'h00, 0, 8'd0, 8'h00);
        n_chk++; if (loop_active !== 1'b1 || loop_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_start got act=%0h addr=%0h want 1 00", loop_active, loop_addr); end
        tick();
        set(1, 8'h01, 0, 8'd0, 8'h00); tick();
        set(1, 8'h02, 0, 8'd0, 8'h00);
        n_chk++; if (loop_jmp !== 1'b0) begin n_fail++; $display("FAIL wrap_nojmp got %0h want 0", loop_jmp); end
        tick();
        set(1, 8'h03, 0, 8'd0, 8'h00);
        n_chk++; if (loop_depth !== 3'd0) begin n_fail++; $display("FAIL wrap_pop got %0d want 0", loop_depth); end
    endtask

    task automatic test_collision();
        do_reset();
        set(1, 8'h60, 1, 8'd3, 8'h62); tick();
        set(1, 8'h62, 1, 8'd1, 8'h70);
        n_chk++; if (loop_jmp !== 1'b0) begin n_fail++; $display("FAIL coll_jmp got %0h want 0", loop_jmp); end
        tick();
        set(1, 8'h63, 0, 8'd0, 8'h00);
        n_chk++; if (loop_depth !== 3'd2 || loop_err !== 1'b1) begin n_fail++; $display("FAIL coll_state got d=%0d e=%0h want 2 1", loop_depth, loop_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set(1, 8'h40, 1, 8'd3, 8'h42); tick();
        set(1, 8'h41, 0, 8'd0, 8'h00); tick();
        set(0, 8'h42, 0, 8'd0, 8'h00);
        n_chk++; if (loop_jmp !== 1'b0 || loop_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_gate got %0h/%0h want 0/00", loop_jmp, loop_addr); end
        tick();
        set(1, 8'h43, 0, 8'd0, 8'h00);
        n_chk++; if (loop_depth !== 3'd0 || loop_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_depth got %0d/%0h want 0/0", loop_depth, loop_active); end
    endtask

`ifdef LOOP_BREAK_EN
    task automatic test_break();
        do_reset();
        set(1, 8'h50, 1, 8'd2, 8'h5F); tick();
        set(1, 8'h52, 1, 8'd2, 8'h55); tick();
        set(1, 8'h55, 0, 8'd0, 8'h00);
        brk = 1'b1; #1;
        n_chk++; if (loop_jmp !== 1'b0) begin n_fail++; $display("FAIL brk_jmp got %0h want 0", loop_jmp); end
        tick();
        set(1, 8'h5F, 0, 8'd0, 8'h00);
        n_chk++; if (loop_depth !== 3'd1) begin n_fail++; $display("FAIL brk_depth got %0d want 1", loop_depth); end
        n_chk++; if (loop_jmp !== 1'b1 || loop_addr !== 8'h51) begin n_fail++; $display("FAIL brk_outer got %0h/%0h want 1/51", loop_jmp, loop_addr); end
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set($urandom_range(0, 60) != 0, 8'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                8'($urandom_range(0, 3)), 8'($urandom_range(0, 15)));
`ifdef LOOP_BREAK_EN
            brk = ($urandom_range(0, 15) == 0); #1;
`endif
            n_chk++; if (loop_jmp !== e_jmp()) begin n_fail++; $display("FAIL rnd_jmp cyc %0d got %0h want %0h", i, loop_jmp, e_jmp()); end
            n_chk++; if (loop_addr !== e_addr()) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %0h want %0h", i, loop_addr, e_addr()); end
            n_chk++; if (loop_depth !== 3'(fr.size())) begin n_fail++; $display("FAIL rnd_depth cyc %0d got %0d want %0d", i, loop_depth, fr.size()); end
            n_chk++; if (loop_active !== (fr.size() != 0)) begin n_fail++; $display("FAIL rnd_active cyc %0d got %0h want %0h", i, loop_active, fr.size() != 0); end
            n_chk++; if (loop_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %0h want %0h", i, loop_err, m_err); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; ls = 1'b0; cnt = '0; ea = '0; brk = 1'b0;
        m_err = 0;
        #1;
        test_reset();
        test_single();
        test_nested();
        test_overflow();
        test_wrap_zero();
        test_collision();
        test_reset_mid();
`ifdef LOOP_BREAK_EN
        test_break();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
